// File: rtl/pitch_cmd_tx.sv
// Pitch command transmitter: quantises the stick reading to a 0..40 code and
// sends a 3-byte UART-style frame (sync, code, checksum), LSB first, 8N1.
module pitch_cmd_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] stick_val,
  input  logic       send_req,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [7:0] pitch_code
);

  localparam int unsigned        CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0]         NEUTRAL = 8'd20;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [1:0]       byte_idx;
  logic [7:0]       checksum;
  logic [13:0]      product;
  logic [7:0]       code_new;
  logic [7:0]       cur_byte;
  logic             bit_end;
  logic             frame_end;

  // 255*41 = 10455 fits in 14 bits, so the shifted result never exceeds 40.
  always_comb begin
    product  = 14'(stick_val) * 14'd41;
    code_new = 8'(product >> 8);
  end

  always_comb begin
    case (byte_idx)
      2'd0:    cur_byte = SYNC_BYTE;
      2'd1:    cur_byte = pitch_code;
      default: cur_byte = checksum;
    endcase
  end

  assign bit_end   = (clk_cnt == CNT_MAX);
  assign frame_end = (state == STOP) && bit_end && (byte_idx == 2'd2);

  always_comb begin
    state_nxt = state;
    tx        = 1'b1;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (send_req) state_nxt = START;
      START: begin
        tx = 1'b0;
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        tx = cur_byte[bit_idx];
        if (bit_end && (bit_idx == 3'd7)) state_nxt = STOP;
      end
      STOP: begin
        if (bit_end) state_nxt = (byte_idx == 2'd2) ? IDLE : START;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      checksum   <= '0;
      pitch_code <= NEUTRAL;
      done       <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= frame_end;
      case (state)
        IDLE: begin
          clk_cnt  <= '0;
          bit_idx  <= '0;
          byte_idx <= '0;
          if (send_req) begin
            pitch_code <= code_new;
            checksum   <= SYNC_BYTE ^ code_new;
          end
        end
        START: clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
        DATA: begin
          clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
          if (bit_end) bit_idx <= (bit_idx == 3'd7) ? 3'd0 : bit_idx + 3'd1;
        end
        STOP: begin
          clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
          if (bit_end) byte_idx <= (byte_idx == 2'd2) ? 2'd0 : byte_idx + 2'd1;
        end
        default: clk_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pitch_cmd_tx.sv
// Scoreboard bench for pitch_cmd_tx: expected frame bytes are queued at request
// time and popped by a UART monitor decoding tx.
module tb_pitch_cmd_tx;
  localparam int unsigned CPB  = 4;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] stick_val = 8'd0;
  logic       send_req = 1'b0;
  logic       tx, busy, done;
  logic [7:0] pitch_code;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int rst_cnt  = 0;
  logic [7:0] exp_q[$];

  pitch_cmd_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst(rst), .stick_val(stick_val), .send_req(send_req),
    .tx(tx), .busy(busy), .done(done), .pitch_code(pitch_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_code(input int unsigned s);
    return 8'((s * 41) / 256);
  endfunction

  always @(negedge clk) if (done === 1'b1) done_cnt++;
  always @(posedge clk) if (rst) rst_cnt++;

  // UART monitor: samples mid-bit; bytes spanning a reset are discarded.
  initial begin
    logic [7:0] b;
    logic       sb, pb;
    int         snap;
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && !rst) begin
        snap = rst_cnt;
        repeat (CPB / 2) @(negedge clk);
        sb = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        pb = tx;
        if (rst_cnt == snap) begin
          check("start_bit", 32'(sb), 32'd0);
          check("stop_bit", 32'(pb), 32'd1);
          if (exp_q.size() == 0) check("unexpected_byte", 32'(b), 32'h100);
          else check("frame_byte", 32'(b), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic push_frame(input logic [7:0] code);
    exp_q.push_back(SYNC);
    exp_q.push_back(code);
    exp_q.push_back(SYNC ^ code);
  endtask

  task automatic send_frame(input logic [7:0] s);
    @(negedge clk);
    stick_val = s;
    send_req  = 1'b1;
    push_frame(model_code(s));
    @(negedge clk);
    send_req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_frame(input logic [7:0] s, input logic [7:0] exp_code);
    int d0;
    d0 = done_cnt;
    send_frame(s);
    check("code_latched", 32'(pitch_code), 32'(exp_code));
    wait_done(40 * CPB);
    repeat (3) @(negedge clk);
    check("one_done", 32'(done_cnt - d0), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("code_held", 32'(pitch_code), 32'(exp_code));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int busy_cycles, d0;
    // reset behaviour
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_tx", 32'(tx), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_code", 32'(pitch_code), 32'd20);
    end

    // neutral frame with busy-length measurement
    d0 = done_cnt;
    send_frame(8'd128);
    check("neutral_code", 32'(pitch_code), 32'h14);
    check("neutral_start_tx", 32'(tx), 32'd0);
    busy_cycles = 0;
    for (int n = 0; n < 200 && done !== 1'b1; n++) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
    end
    check("busy_len", 32'(busy_cycles), 32'(30 * CPB));
    check("busy_at_done", 32'(busy), 32'd0);
    check("done_seen", 32'(done), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    check("neutral_one_done", 32'(done_cnt - d0), 32'd1);
    check("neutral_queue_empty", 32'(exp_q.size()), 32'd0);

    // extremes
    run_frame(8'd0, 8'h00);
    run_frame(8'd255, 8'h28);
    run_frame(8'd200, 8'h20);

    // request while busy is ignored
    d0 = done_cnt;
    send_frame(8'd128);
    repeat (48) @(negedge clk);
    stick_val = 8'd0;
    send_req  = 1'b1;
    @(negedge clk);
    send_req = 1'b0;
    check("busy_req_code", 32'(pitch_code), 32'd20);
    wait_done(40 * CPB);
    repeat (20) @(negedge clk);
    check("busy_req_one_done", 32'(done_cnt - d0), 32'd1);
    check("busy_req_not_queued", 32'(busy), 32'd0);
    check("busy_req_code_held", 32'(pitch_code), 32'd20);
    check("busy_req_queue", 32'(exp_q.size()), 32'd0);

    // reset during byte 1 DATA
    d0 = done_cnt;
    send_frame(8'd200);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_code", 32'(pitch_code), 32'd20);
    check("rst_done", 32'(done), 32'd0);
    exp_q.delete();
    repeat (60) @(negedge clk);
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);
    run_frame(8'd200, 8'h20);

    // back-to-back with send_req held
    d0 = done_cnt;
    @(negedge clk);
    stick_val = 8'd200;
    send_req  = 1'b1;
    push_frame(model_code(200));
    push_frame(model_code(200));
    @(negedge clk);
    wait_done(40 * CPB);
    check("b2b_idle_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("b2b_busy_next", 32'(busy), 32'd1);
    check("b2b_start_next", 32'(tx), 32'd0);
    send_req = 1'b0;
    wait_done(40 * CPB);
    repeat (3) @(negedge clk);
    check("b2b_two_done", 32'(done_cnt - d0), 32'd2);
    check("b2b_code", 32'(pitch_code), 32'h20);
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pitch_cmd_tx.md
Name: pitch_cmd_tx

Overview:
- Controller-side transmitter for the pitch command link; the drone-side pitch offset logic consumes the byte it sends.
- Quantises a raw 8-bit stick reading into the 0..40 pitch code. 20 is neutral; the receiver's no-offset band is 19..22.
- Sends the code as a 3-byte UART-style frame: sync byte, pitch code, checksum.
- Sits between the stick ADC sampler and the RF/serial pin driver.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200). Legal minimum is 2.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stick_val  in  8  raw stick position: 0 = full forward, 255 = full back.
- send_req  in  1  one-cycle request to transmit a frame. Sampled only in IDLE.
- tx  out  1  serial line; idles high.
- busy  out  1  high while a frame is in flight.
- done  out  1  one-cycle pulse when a frame completes.
- pitch_code  out  8  code latched for the current or last frame, range 0..40.

Behaviour:
- Reset values (rst high at a clock edge):
  - tx=1, busy=0, done=0, pitch_code=8'd20.
  - State=IDLE; all counters cleared.
  - Reset mid-frame aborts the frame immediately, tx returns high, and no done pulse is produced.
- Quantisation: pitch_code = (stick_val * 41) >> 8.
  - Use a 14-bit intermediate product.
  - Result is always 0..40: 0 maps to 0, 128 maps to 20, 255 maps to 40. No clamping is needed.
- Request handling:
  - send_req=1 in IDLE at edge N latches pitch_code, checksum = SYNC_BYTE ^ code, and the byte index (0).
  - busy=1 and tx=0 (start bit of byte 0) from edge N+1.
  - send_req while busy is ignored and is not queued.
  - stick_val changes during a frame have no effect.
- Frame bytes, in order:
  - byte 0 = SYNC_BYTE
  - byte 1 = pitch_code
  - byte 2 = checksum
- Each byte is 10 bits:
  - start bit (0)
  - 8 data bits, LSB first
  - stop bit (1)
  - Every bit is held exactly CLKS_PER_BIT cycles.
  - Bytes are back-to-back with no idle gap.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on send_req.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> DATA for bits 0..6; DATA -> STOP after bit 7.
  - STOP -> START with byte index +1 if the index is below 2.
  - STOP -> IDLE if the index equals 2.
- Frame length: 30*CLKS_PER_BIT cycles from the first start-bit cycle to the end of the last stop bit.
- Completion: on the STOP -> IDLE transition, busy=0 and done=1 for exactly one cycle.
  - pitch_code holds its value until the next accepted request.
- Back-to-back frames: send_req asserted in the same cycle done is high is accepted, since the FSM is already in IDLE. The new start bit follows on the next edge.
- Counters:
  - The bit-time counter runs 0..CLKS_PER_BIT-1 and wraps.
  - The bit index runs 0..7; the byte index runs 0..2.
  - No counter wraps outside its state.

Test Plan:
- Reset behaviour: hold rst 3 cycles, then idle 10 cycles -> tx=1, busy=0, done=0, pitch_code=20 throughout.
- Neutral frame: CLKS_PER_BIT=4, stick_val=128, one send_req pulse.
  - pitch_code=20 (0x14).
  - tx carries A5, 14, B1, LSB first, each byte framed by start/stop.
  - busy is high for 120 cycles, then done pulses once.
- Extremes:
  - stick_val=0 -> code 0x00, checksum 0xA5.
  - stick_val=255 -> code 0x28, checksum 0x8D.
  - Decode tx with a bench UART monitor and compare.
- Request while busy: assert send_req at cycle 50 of a frame with stick_val changed to 0 -> ignored; frame bytes and pitch_code are unchanged; exactly one done pulse.
- Reset mid-frame: assert rst during byte 1 DATA -> next cycle tx=1, busy=0, pitch_code=20, no done. A fresh send_req then yields a complete, correct frame.
- Back-to-back: hold send_req high continuously with stick_val=200 (code 32 = 0x20, checksum 0x85).
  - Two consecutive frames.
  - Second start bit begins one cycle after done.
  - Both frames decode correctly.
